// File: rtl/kyber_pkg.sv
// Shared Kyber constants and types for the byte-decode and compress datapath.
package kyber_pkg;

  localparam int Q          = 3329;
  localparam int NUM_COEFFS = 256;
  localparam int MAX_ELL    = 12;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic [MAX_ELL-1:0] coeff_t;

  // Bytes needed to carry n coefficients of d bits each.
  function automatic int unsigned poly_bytes(input int unsigned d, input int unsigned n);
    return (n * d) / 8;
  endfunction

endpackage

// File: rtl/mod_q_cond_sub.sv
// Conditional single subtract of Q; valid for inputs below 2Q. Shared with compress.
module mod_q_cond_sub #(
  parameter int W = kyber_pkg::MAX_ELL,
  parameter int Q = kyber_pkg::Q
) (
  input  logic [W-1:0] raw,
  output logic [W-1:0] res,
  output logic         ovf
);

  always_comb begin
    ovf = (raw >= W'(Q));
    res = ovf ? (raw - W'(Q)) : raw;
  end

endmodule

// File: rtl/stream_byte_decode.sv
// Streaming ByteDecode_d: bytes in over valid/ready, one d-bit coefficient out per handshake.
module stream_byte_decode #(
  parameter int MAX_ELL    = kyber_pkg::MAX_ELL,
  parameter int NUM_COEFFS = kyber_pkg::NUM_COEFFS,
  parameter int Q          = kyber_pkg::Q
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [3:0]                    d_i,
  input  logic [7:0]                    byte_i,
  input  logic                          byte_valid_i,
  output logic                          byte_ready_o,
  output logic [MAX_ELL-1:0]            coeff_o,
  output logic [$clog2(NUM_COEFFS)-1:0] coeff_idx_o,
  output logic                          coeff_valid_o,
  input  logic                          coeff_ready_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          range_err_o
);
  import kyber_pkg::state_t;
  import kyber_pkg::IDLE;
  import kyber_pkg::RUN;
  import kyber_pkg::DONE;

  localparam int ACC_W = MAX_ELL + 8;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int BL_W  = $clog2(NUM_COEFFS * MAX_ELL / 8 + 1);
  localparam int IDX_W = $clog2(NUM_COEFFS);

  state_t           state;
  logic [3:0]       d;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [BL_W-1:0]  bytes_left;
  logic [IDX_W-1:0] idx;

  logic [MAX_ELL-1:0] mask, raw, red;
  logic               ovf, push, pop, start_ok, full_w;
  logic [CNT_W-1:0]   cnt_pop;
  logic [ACC_W-1:0]   acc_sh, byte_ext;

  mod_q_cond_sub #(.W(MAX_ELL), .Q(Q)) u_modq (
    .raw (raw),
    .res (red),
    .ovf (ovf)
  );

  // The incoming byte lands just above whatever survives this cycle's pop.
  always_comb begin
    full_w        = (d == 4'(MAX_ELL));
    mask          = ~({MAX_ELL{1'b1}} << d);
    raw           = acc[MAX_ELL-1:0] & mask;
    byte_ready_o  = (state == RUN) && (bytes_left != '0) && (cnt <= CNT_W'(ACC_W - 8));
    coeff_valid_o = (state == RUN) && (cnt >= CNT_W'(d));
    coeff_o       = full_w ? red : raw;
    push          = byte_valid_i && byte_ready_o;
    pop           = coeff_valid_o && coeff_ready_i;
    cnt_pop       = pop ? (cnt - CNT_W'(d)) : cnt;
    acc_sh        = pop ? (acc >> d) : acc;
    byte_ext      = ACC_W'(byte_i) << cnt_pop;
    start_ok      = start_i && (d_i != 4'd0) && (d_i <= 4'(MAX_ELL));
  end

  assign busy_o      = (state != IDLE);
  assign coeff_idx_o = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      d           <= '0;
      acc         <= '0;
      cnt         <= '0;
      bytes_left  <= '0;
      idx         <= '0;
      done_o      <= 1'b0;
      range_err_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: if (start_ok) begin
          state       <= RUN;
          d           <= d_i;
          acc         <= '0;
          cnt         <= '0;
          idx         <= '0;
          range_err_o <= 1'b0;
          bytes_left  <= BL_W'(kyber_pkg::poly_bytes(32'(d_i), NUM_COEFFS));
        end
        RUN: begin
          acc <= acc_sh | (push ? byte_ext : '0);
          cnt <= cnt_pop + (push ? CNT_W'(8) : '0);
          if (push) bytes_left <= bytes_left - BL_W'(1);
          if (pop) begin
            idx <= idx + IDX_W'(1);
            if (full_w && ovf) range_err_o <= 1'b1;
            if (idx == IDX_W'(NUM_COEFFS - 1)) begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_byte_decode.sv
// Directed bench for stream_byte_decode: fixed vectors plus a bit-array reference decode.
module tb_stream_byte_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  d_i = 4'd0;
  logic [7:0]  byte_i = 8'd0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic [11:0] coeff_o;
  logic [7:0]  coeff_idx_o;
  logic        coeff_valid_o;
  logic        coeff_ready_i = 1'b0;
  logic        busy_o, done_o, range_err_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] src [0:511];
  int         got [0:255];

  int r_ncoef, r_nacc, r_ndone, r_stall_bad, r_idx_bad, r_first_b, r_first_c, r_last_c;
  bit r_timeout;

  always #5 clk = ~clk;

  stream_byte_decode dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .d_i           (d_i),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .byte_ready_o  (byte_ready_o),
    .coeff_o       (coeff_o),
    .coeff_idx_o   (coeff_idx_o),
    .coeff_valid_o (coeff_valid_o),
    .coeff_ready_i (coeff_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .range_err_o   (range_err_o)
  );

  // Reference: gather d bits LSB-first straight out of the byte array.
  function automatic int ref_coef(input int i, input int d);
    int v = 0;
    for (int k = 0; k < d; k++) begin
      int p = i * d + k;
      v |= ((int'(src[p / 8]) >> (p % 8)) & 1) << k;
    end
    if (d == 12 && v >= 3329) v -= 3329;
    return v;
  endfunction

  task automatic fill(input int seed_mul, input int seed_add);
    for (int i = 0; i < 512; i++) src[i] = 8'((i * seed_mul + seed_add) & 255);
  endtask

  task automatic do_start(input int d);
    start_i = 1'b1;
    d_i     = 4'(d);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Drives bytes/ready until done_o (or stop_at coefficient handshakes), recording results.
  task automatic stream(input int stop_at, input bit rnd, input int poke_at);
    int         cyc = 0;
    bit         pv  = 0;
    logic [11:0] pc = '0;
    bit         hs_b, hs_c;
    r_ncoef = 0; r_nacc = 0; r_ndone = 0; r_stall_bad = 0; r_idx_bad = 0;
    r_first_b = -1; r_first_c = -1; r_last_c = -1; r_timeout = 0;
    forever begin
      if (done_o) r_ndone++;
      if (pv && !(coeff_valid_o && coeff_o == pc)) r_stall_bad++;
      if (r_ndone > 0 || r_ncoef == stop_at) break;
      if (cyc > 6000) begin r_timeout = 1; break; end
      if (coeff_valid_o && coeff_idx_o != 8'(r_ncoef)) r_idx_bad++;
      start_i = (cyc == poke_at);
      if (cyc == poke_at) d_i = 4'd3;
      byte_valid_i  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      coeff_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_i        = src[r_nacc < 512 ? r_nacc : 511];
      hs_b = byte_valid_i && byte_ready_o;
      hs_c = coeff_valid_o && coeff_ready_i;
      if (hs_c) begin
        if (r_ncoef < 256) got[r_ncoef] = int'(coeff_o);
        if (r_first_c < 0) r_first_c = cyc;
        r_last_c = cyc;
        r_ncoef++;
      end
      if (hs_b) begin
        if (r_first_b < 0) r_first_b = cyc;
        r_nacc++;
      end
      pv = coeff_valid_o && !coeff_ready_i;
      pc = coeff_o;
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0; byte_valid_i = 1'b0; coeff_ready_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    total++; if (byte_ready_o !== 1'b0) begin bad++; $display("FAIL %s byte_ready got=%b want=0", tag, byte_ready_o); end
    total++; if (coeff_valid_o !== 1'b0) begin bad++; $display("FAIL %s coeff_valid got=%b want=0", tag, coeff_valid_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL %s busy got=%b want=0", tag, busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL %s done got=%b want=0", tag, done_o); end
    total++; if (range_err_o !== 1'b0) begin bad++; $display("FAIL %s range_err got=%b want=0", tag, range_err_o); end
    total++; if (coeff_o !== 12'd0) begin bad++; $display("FAIL %s coeff got=%0d want=0", tag, coeff_o); end
    total++; if (coeff_idx_o !== 8'd0) begin bad++; $display("FAIL %s coeff_idx got=%0d want=0", tag, coeff_idx_o); end
  endtask

  task automatic check_run(input string tag, input int d, input int want_err);
    total++; if (r_timeout) begin bad++; $display("FAIL %s timeout got=1 want=0", tag); end
    total++; if (r_ncoef !== 256) begin bad++; $display("FAIL %s ncoef got=%0d want=256", tag, r_ncoef); end
    total++; if (r_nacc !== 32 * d) begin bad++; $display("FAIL %s bytes got=%0d want=%0d", tag, r_nacc, 32 * d); end
    total++; if (r_ndone !== 1) begin bad++; $display("FAIL %s done got=%0d want=1", tag, r_ndone); end
    total++; if (r_stall_bad !== 0) begin bad++; $display("FAIL %s stall_stable got=%0d want=0", tag, r_stall_bad); end
    total++; if (r_idx_bad !== 0) begin bad++; $display("FAIL %s coeff_idx got=%0d want=0", tag, r_idx_bad); end
    total++; if (int'(range_err_o) !== want_err) begin bad++; $display("FAIL %s range_err got=%b want=%0d", tag, range_err_o, want_err); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_start();
    do_start(0);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL illegal_d0 busy got=%b want=0", busy_o); end
    total++; if (byte_ready_o !== 1'b0) begin bad++; $display("FAIL illegal_d0 byte_ready got=%b want=0", byte_ready_o); end
    do_start(13);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL illegal_d13 busy got=%b want=0", busy_o); end
    @(posedge clk); #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL illegal_d13_hold busy got=%b want=0", busy_o); end
  endtask

  task automatic test_d12_basic();
    for (int i = 0; i < 512; i++) src[i] = 8'h00;
    src[0] = 8'h49; src[1] = 8'h8B; src[2] = 8'h0B;
    do_start(12);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL d12_start busy got=%b want=1", busy_o); end
    total++; if (byte_ready_o !== 1'b1) begin bad++; $display("FAIL d12_start byte_ready got=%b want=1", byte_ready_o); end
    stream(1000, 1'b0, -1);
    check_run("d12_basic", 12, 0);
    total++; if (got[0] !== 2889) begin bad++; $display("FAIL d12_c0 got=%0d want=2889", got[0]); end
    total++; if (got[1] !== 184) begin bad++; $display("FAIL d12_c1 got=%0d want=184", got[1]); end
    for (int i = 2; i < 256; i++) begin
      total++; if (got[i] !== 0) begin bad++; $display("FAIL d12_c%0d got=%0d want=0", i, got[i]); end
    end
    @(posedge clk); #1;
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL d12_done_pulse got=%b want=0", done_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL d12_idle busy got=%b want=0", busy_o); end
  endtask

  task automatic test_range_err();
    for (int i = 0; i < 512; i++) src[i] = 8'h00;
    src[0] = 8'hFF; src[1] = 8'hFF; src[2] = 8'hFF;
    do_start(12);
    stream(1000, 1'b0, -1);
    check_run("d12_range", 12, 1);
    total++; if (got[0] !== 766) begin bad++; $display("FAIL range_c0 got=%0d want=766", got[0]); end
    total++; if (got[1] !== 766) begin bad++; $display("FAIL range_c1 got=%0d want=766", got[1]); end
    total++; if (got[2] !== 0) begin bad++; $display("FAIL range_c2 got=%0d want=0", got[2]); end
    @(posedge clk); #1;
    total++; if (range_err_o !== 1'b1) begin bad++; $display("FAIL range_hold got=%b want=1", range_err_o); end
    src[0] = 8'h00; src[1] = 8'h00; src[2] = 8'h00;
    do_start(12);
    total++; if (range_err_o !== 1'b0) begin bad++; $display("FAIL range_clear got=%b want=0", range_err_o); end
    stream(1000, 1'b0, -1);
    check_run("d12_clean", 12, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_d1();
    int exp_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    fill(37, 3);
    src[0] = 8'hA5;
    do_start(1);
    stream(1000, 1'b0, -1);
    check_run("d1", 1, 0);
    for (int i = 0; i < 8; i++) begin
      total++; if (got[i] !== exp_a5[i]) begin bad++; $display("FAIL d1_c%0d got=%0d want=%0d", i, got[i], exp_a5[i]); end
    end
    for (int i = 8; i < 256; i++) begin
      total++; if (got[i] !== ref_coef(i, 1)) begin bad++; $display("FAIL d1_c%0d got=%0d want=%0d", i, got[i], ref_coef(i, 1)); end
    end
    total++; if (r_first_b !== 0) begin bad++; $display("FAIL d1_first_byte got=%0d want=0", r_first_b); end
    total++; if (r_first_c !== r_first_b + 1) begin bad++; $display("FAIL d1_first_coeff got=%0d want=%0d", r_first_c, r_first_b + 1); end
    total++; if (r_last_c - r_first_c !== 255) begin bad++; $display("FAIL d1_rate got=%0d want=255", r_last_c - r_first_c); end
    @(posedge clk); #1;
  endtask

  task automatic test_d10_stall();
    fill(53, 11);
    do_start(10);
    stream(1000, 1'b1, 40);
    check_run("d10_stall", 10, 0);
    for (int i = 0; i < 256; i++) begin
      total++; if (got[i] !== ref_coef(i, 10)) begin bad++; $display("FAIL d10_c%0d got=%0d want=%0d", i, got[i], ref_coef(i, 10)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    fill(91, 5);
    do_start(4);
    stream(100, 1'b0, -1);
    total++; if (r_ncoef !== 100) begin bad++; $display("FAIL mid_ncoef got=%0d want=100", r_ncoef); end
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    fill(29, 7);
    do_start(11);
    stream(1000, 1'b0, -1);
    check_run("d11_after_reset", 11, 0);
    for (int i = 0; i < 256; i++) begin
      total++; if (got[i] !== ref_coef(i, 11)) begin bad++; $display("FAIL d11_c%0d got=%0d want=%0d", i, got[i], ref_coef(i, 11)); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_illegal_start();
    test_d12_basic();
    test_range_err();
    test_d1();
    test_d10_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
